instr_prefetch_unit: RTL and testbench

Parametrised instruction fetch front end with a prefetch queue. It replaces the single-PC fetch stage by decoupling PC generation from the instruction memory and from decode. Requests go out over a request/grant/response handshake, up to DEPTH fetches may be in flight, and PC/instruction pairs are delivered to decode over valid/ready. A redirect (branch/jump/trap) flushes all queued and in-flight wrong-path instructions. Sits between the instruction cache/memory port and the decode stage.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_slot_ring.sv | 90 +++++++++
 rtl/instr_prefetch_unit.sv | 112 +++++++++++
 tb/tb_instr_prefetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and helpers for the instruction prefetch  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Slot fields are sized for the widest supported configuration; narrower
  // instances zero-extend on write and truncate on read.
  localparam int unsigned SLOT_XLEN = 64;
  localparam int unsigned SLOT_ILEN = 32;

  typedef struct packed {
    logic [SLOT_XLEN-1:0] pc;
    logic [SLOT_ILEN-1:0] instr;
    logic                 filled;
  } slot_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_slot_ring.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_slot_ring : circular slot store with alloc/fill/head pointers |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module fetch_slot_ring
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         alloc_i,
  input  logic [XLEN-1:0]              alloc_pc_i,
  input  logic                         fill_i,
  input  logic [ILEN-1:0]              fill_instr_i,
  input  logic                         pop_i,
  output logic                         head_valid_o,
  output logic [XLEN-1:0]              head_pc_o,
  output logic [ILEN-1:0]              head_instr_o,
  output logic [cnt_width(DEPTH)-1:0]  alloc_cnt_o,
  output logic [cnt_width(DEPTH)-1:0]  filled_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  slot_t           slots_q [DEPTH];
  logic [PW-1:0]   alloc_ptr_q;
  logic [PW-1:0]   fill_ptr_q;
  logic [PW-1:0]   head_ptr_q;
  logic [CW-1:0]   alloc_cnt_q;
  logic [CW-1:0]   w_filled_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slots_q[i] <= '0;
      end
    end else if (flush_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slots_q[i].filled <= 1'b0;
      end
    end else begin
      // Alloc, fill and pop always target distinct slots while the
      // occupancy bound on requests holds, so their writes never collide.
      if (alloc_i) begin
        slots_q[alloc_ptr_q].pc     <= SLOT_XLEN'(alloc_pc_i);
        slots_q[alloc_ptr_q].filled <= 1'b0;
        alloc_ptr_q                 <= alloc_ptr_q + PW'(1);
      end
      if (fill_i) begin
        slots_q[fill_ptr_q].instr  <= SLOT_ILEN'(fill_instr_i);
        slots_q[fill_ptr_q].filled <= 1'b1;
        fill_ptr_q                 <= fill_ptr_q + PW'(1);
      end
      if (pop_i) begin
        slots_q[head_ptr_q].filled <= 1'b0;
        head_ptr_q                 <= head_ptr_q + PW'(1);
      end
      alloc_cnt_q <= alloc_cnt_q + CW'(alloc_i) - CW'(pop_i);
    end
  end

  always_comb begin
    w_filled_cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_filled_cnt = w_filled_cnt + CW'(slots_q[i].filled);
    end
  end

  assign head_valid_o = slots_q[head_ptr_q].filled;
  assign head_pc_o    = XLEN'(slots_q[head_ptr_q].pc);
  assign head_instr_o = ILEN'(slots_q[head_ptr_q].instr);
  assign alloc_cnt_o  = alloc_cnt_q;
  assign filled_cnt_o = w_filled_cnt;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_prefetch_unit : decoupled fetch front end with prefetch queue |
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module instr_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   w_alloc_cnt;
  logic [CW-1:0]   w_filled_cnt;
  logic [CW:0]     w_occupancy;
  logic            w_grant;
  logic            w_fill;
  logic            w_pop;
  logic            w_head_valid;
  logic [XLEN-1:0] w_head_pc;
  logic [ILEN-1:0] w_head_instr;

  // Occupancy counts live slots plus responses still owed to a flushed path,
  // so a redirect cannot let in-flight traffic exceed DEPTH.
  assign w_occupancy = {1'b0, w_alloc_cnt} + {1'b0, drop_cnt_q};
  assign imem_req_o  = (w_occupancy < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign w_grant = imem_req_o & imem_gnt_i;
  assign w_fill  = imem_rvalid_i & (drop_cnt_q == '0);
  assign w_pop   = w_head_valid & instr_ready_i;

  fetch_slot_ring #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect_i),
    .alloc_i      (w_grant),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (w_fill),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (w_pop),
    .head_valid_o (w_head_valid),
    .head_pc_o    (w_head_pc),
    .head_instr_o (w_head_instr),
    .alloc_cnt_o  (w_alloc_cnt),
    .filled_cnt_o (w_filled_cnt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~XLEN'(3);
      // Every old-path response not yet received becomes a drop, including
      // one granted now, less one arriving now.
      drop_cnt_d = drop_cnt_q + (w_alloc_cnt - w_filled_cnt)
                 + CW'(w_grant) - CW'(imem_rvalid_i);
    end else begin
      if (w_grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rvalid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign instr_valid_o = w_head_valid;
  assign instr_o       = w_head_valid ? w_head_instr : NOP_INSTR;
  assign pc_o          = w_head_valid ? w_head_pc : '0;

  a_occupancy_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_occupancy <= (CW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_prefetch_unit : scoreboard bench with randomized memory    |
// | Revision               : 1.0                                        |
// +--------------------------------------------------------------------+
module tb_instr_prefetch_unit;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            redirect_i = 1'b0;
  logic [XLEN-1:0] redirect_pc_i = '0;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i = 1'b0;
  logic            imem_rvalid_i = 1'b0;
  logic [ILEN-1:0] imem_rdata_i = '0;
  logic            instr_valid_o;
  logic            instr_ready_i = 1'b0;
  logic [ILEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;

  instr_prefetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       pending[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_fetch;
  int unsigned cyc;
  int unsigned n_grant;
  int unsigned n_pop;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  int unsigned gnt_prob, ready_prob, redir_prob, lat_min, lat_max;
  bit          redir_now;
  logic [63:0] redir_target;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[33:2] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    repeat (2) @(negedge clk_i);
    pending.delete();
    exp_q.delete();
    exp_fetch = 64'h0;
    cyc = 0;
    n_grant = 0;
    redir_now = 1'b0;
    rst_ni = 1'b1;
  endtask

  // Drive one cycle of memory/decode/redirect stimulus, update the model, advance.
  task automatic step();
    bit          redir;
    logic [63:0] tgt;
    imem_gnt_i    = ($urandom_range(99, 0) < gnt_prob);
    instr_ready_i = ($urandom_range(99, 0) < ready_prob);
    redir = redir_now || ($urandom_range(99, 0) < redir_prob);
    tgt   = redir_now ? redir_target : {48'h0, 16'($urandom)};
    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    if (imem_req_o && imem_gnt_i) begin
      check("imem_addr", imem_addr_o, exp_fetch);
      pending.push_back('{addr: imem_addr_o, due: cyc + $urandom_range(lat_max, lat_min)});
      n_grant++;
      if (!redir) exp_q.push_back(exp_fetch);
      exp_fetch = exp_fetch + 64'd4;
    end
    if (redir) begin
      exp_q.delete();
      exp_fetch = tgt & ~64'h3;
    end
    if (pending.size() > DEPTH) check("outstanding_le_depth", 64'(pending.size()), 64'(DEPTH));
    cyc++;
    redir_now = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic knobs(input int unsigned g, input int unsigned r, input int unsigned rd,
                       input int unsigned lmin, input int unsigned lmax);
    gnt_prob = g; ready_prob = r; redir_prob = rd; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    knobs(0, 100, 0, 1, 1);
    n = 0;
    while ((exp_q.size() > 0 || pending.size() > 0) && n < 100) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size() + pending.size()), 64'd0);
  endtask

  // Monitor: compares every delivered instruction against the scoreboard.
  initial begin
    logic [63:0] e;
    n_pop = 0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni) begin
        if (!instr_valid_o) begin
          check("empty_instr", 64'(instr_o), 64'(NOP));
          check("empty_pc", pc_o, 64'h0);
        end else if (instr_ready_i && !redirect_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_delivery", pc_o, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            e = exp_q.pop_front();
            check("deliver_pc", pc_o, e);
            check("deliver_instr", 64'(instr_o), 64'(mem(e)));
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    knobs(100, 100, 0, 1, 1);

    // Reset state, then streaming with a 1-cycle memory.
    do_reset();
    check("rst_req", 64'(imem_req_o), 64'd1);
    check("rst_addr", imem_addr_o, 64'h0);
    check("rst_valid", 64'(instr_valid_o), 64'd0);
    check("rst_instr", 64'(instr_o), 64'(NOP));
    check("rst_pc", pc_o, 64'h0);
    step();
    step();
    for (int k = 2; k < 10; k++) begin
      check("stream_valid", 64'(instr_valid_o), 64'd1);
      check("stream_pc", pc_o, 64'(4 * (k - 2)));
      check("stream_addr", imem_addr_o, 64'(4 * k));
      step();
    end
    drain("stream_drain");

    // Full queue with decode stalled.
    do_reset();
    knobs(100, 0, 0, 1, 1);
    repeat (8) step();
    check("full_grants", 64'(n_grant), 64'd4);
    check("full_req", 64'(imem_req_o), 64'd0);
    check("full_valid", 64'(instr_valid_o), 64'd1);
    check("full_pc", pc_o, 64'h0);
    ready_prob = 100;
    step();
    ready_prob = 0;
    check("after_pop_req", 64'(imem_req_o), 64'd1);
    check("after_pop_addr", imem_addr_o, 64'h10);
    check("after_pop_pc", pc_o, 64'h4);
    repeat (3) step();
    check("after_pop_grants", 64'(n_grant), 64'd5);
    check("after_pop_req_low", 64'(imem_req_o), 64'd0);
    drain("full_drain");

    // Redirect with three outstanding and a response arriving that cycle.
    do_reset();
    knobs(100, 0, 0, 3, 3);
    repeat (3) step();
    gnt_prob = 0;
    redir_now = 1'b1;
    redir_target = 64'h1003;
    step();
    check("redir_req", 64'(imem_req_o), 64'd1);
    check("redir_addr", imem_addr_o, 64'h1000);
    check("redir_valid", 64'(instr_valid_o), 64'd0);
    gnt_prob = 100;
    ready_prob = 100;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (instr_valid_o) found = 1'b1;
      else step();
    end
    check("redir_first_found", 64'(found), 64'd1);
    check("redir_first_pc", pc_o, 64'h1000);
    check("redir_first_instr", 64'(instr_o), 64'(mem(64'h1000)));
    drain("redir_drain");

    // Redirect coincident with pop and grant.
    do_reset();
    knobs(100, 100, 0, 1, 1);
    repeat (5) step();
    check("coinc_pre_valid", 64'(instr_valid_o), 64'd1);
    redir_now = 1'b1;
    redir_target = 64'h2000;
    step();
    check("coinc_valid", 64'(instr_valid_o), 64'd0);
    check("coinc_instr", 64'(instr_o), 64'(NOP));
    check("coinc_pc", pc_o, 64'h0);
    check("coinc_addr", imem_addr_o, 64'h2000);
    repeat (10) step();
    drain("coinc_drain");

    // Randomized traffic against the scoreboard.
    do_reset();
    knobs(60, 60, 3, 1, 5);
    repeat (3000) step();
    drain("random_drain");
    check("random_delivered_some", 64'(n_pop > 200), 64'd1);

    // Fetch PC wrap at the top of the address space.
    do_reset();
    knobs(100, 100, 0, 1, 1);
    redir_now = 1'b1;
    redir_target = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    check("wrap_addr_top", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap_addr_zero", imem_addr_o, 64'h0);
    repeat (6) step();
    drain("wrap_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
